id_operand_stage: RTL

Decode-side operand stage that sits directly downstream of the register file. Drives the register file read addresses, resolves RAW hazards by bypassing from EX, MEM and WB, and inserts bubbles on load-use hazards. Captures operands plus decoded control into the ID/EX pipeline register, with a valid/ready handshake toward EX.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/operand_bypass.sv | 38 +++
 rtl/id_operand_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared datapath widths, forwarding-source encoding and the ID/EX register layout
// used by the decode-side operand stage.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 16;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    NONE,
    EX,
    MEM,
    WB,
    ZERO
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [REG_W-1:0]  dst;
    logic              we;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } idex_t;
endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand.
// Priority is r0, then EX, then MEM, then WB, then the register file.
module operand_bypass
  import mips_pkg::*;
(
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_we,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] val,
  output fwd_sel_t          sel
);
  always_comb begin
    sel = NONE;
    val = rf_data;
    if (idx == REG_ZERO) begin
      sel = ZERO;
      val = '0;
    end else if (ex_we && ex_dst == idx) begin
      sel = EX;
      val = ex_data;
    end else if (mem_we && mem_dst == idx) begin
      sel = MEM;
      val = mem_data;
    end else if (wb_we && wb_dst == idx) begin
      // The register file returns the pre-write value, so WB must bypass too.
      sel = WB;
      val = wb_data;
    end
  end
endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: register-file addressing, EX/MEM/WB bypass, load-use bubbles
// and the ID/EX pipeline register with a valid/ready handshake toward EX.
module id_operand_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic              in_uses_rs,
  input  logic              in_uses_rt,
  input  logic [REG_W-1:0]  in_dst,
  input  logic              in_we,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  output logic [REG_W-1:0]  rf_a1,
  output logic [REG_W-1:0]  rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [15:0]       stall_count
);
  idex_t             r_q, r_d;
  logic [15:0]       stall_q, stall_d;
  logic [DATA_W-1:0] rs_val, rt_val;
  fwd_sel_t          rs_sel, rt_sel;
  logic              ex_fwd, adv, hazard;

  assign rf_a1 = in_rs;
  assign rf_a2 = in_rt;

  // A load in EX has no data yet; it is handled as a hazard, never as a bypass.
  assign ex_fwd = r_q.valid && r_q.we && !r_q.is_load;

  operand_bypass u_rs_bypass (
    .idx(in_rs), .rf_data(rf_rd1),
    .ex_we(ex_fwd), .ex_dst(r_q.dst), .ex_data(ex_result),
    .mem_we(mem_we), .mem_dst(mem_dst), .mem_data(mem_wd),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_wd),
    .val(rs_val), .sel(rs_sel)
  );

  operand_bypass u_rt_bypass (
    .idx(in_rt), .rf_data(rf_rd2),
    .ex_we(ex_fwd), .ex_dst(r_q.dst), .ex_data(ex_result),
    .mem_we(mem_we), .mem_dst(mem_dst), .mem_data(mem_wd),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_wd),
    .val(rt_val), .sel(rt_sel)
  );

  always_comb begin
    assert (rs_sel != ZERO || rs_val == '0);
    assert (rt_sel != ZERO || rt_val == '0);
  end

  // Hazard is deliberately not gated by in_valid here so in_ready never depends on it.
  assign hazard = r_q.valid && r_q.is_load && r_q.we && (r_q.dst != REG_ZERO) &&
                  ((in_uses_rs && in_rs == r_q.dst) || (in_uses_rt && in_rt == r_q.dst));
  assign adv      = out_ready || !r_q.valid;
  assign in_ready = adv && !hazard && !flush;

  always_comb begin
    r_d     = r_q;
    stall_d = stall_q;
    if (flush) begin
      r_d.valid = 1'b0;
    end else if (adv) begin
      if (in_valid && hazard) begin
        r_d.valid = 1'b0;
        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      end else if (in_valid) begin
        r_d.valid   = 1'b1;
        r_d.rs_val  = rs_val;
        r_d.rt_val  = rt_val;
        r_d.dst     = in_dst;
        r_d.we      = in_we;
        r_d.is_load = in_is_load;
        r_d.ctrl    = in_ctrl;
        r_d.imm     = in_imm;
        r_d.pc      = in_pc;
      end else begin
        r_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      stall_q <= '0;
    end else begin
      r_q     <= r_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid   = r_q.valid;
  assign out_rs_val  = r_q.rs_val;
  assign out_rt_val  = r_q.rt_val;
  assign out_dst     = r_q.dst;
  assign out_we      = r_q.we;
  assign out_is_load = r_q.is_load;
  assign out_ctrl    = r_q.ctrl;
  assign out_imm     = r_q.imm;
  assign out_pc      = r_q.pc;
  assign stall_count = stall_q;
endmodule
